// File: rtl/pixel_collision_monitor.sv
// Snoops the scanner plot stream, rebuilds runner/pipe column bitmaps per frame and flags overlap.
// Define BOUNDS_CHECK_EN to also flag the runner touching the floor or ceiling row.
module pixel_collision_monitor #(
  parameter int unsigned Y_BASE        = 84,
  parameter int unsigned COL_HEIGHT    = 80,
  parameter int unsigned RUNNER_X      = 1,
  parameter int unsigned PIPE_X        = 2,
  parameter logic [2:0]  RUNNER_COLOUR = 3'b100,
  parameter logic [2:0]  PIPE_COLOUR   = 3'b110
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        frame_done,
  output logic        hit,
  output logic        lose,
  output logic [15:0] frames
);

  localparam int ROW_W = $clog2(COL_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_HEIGHT-1:0]   rmap_q, pmap_q, rmap_d, pmap_d;
  logic [COL_HEIGHT-1:0]   snap_r, snap_p;
  logic [7:0]              last_x;
  logic [8:0]              row_full;
  logic [ROW_W-1:0]        row_idx;
  logic                    pix_ok, at_x0, boundary;
  logic                    record, snap_en, clear_live, coll;

  // Bit 8 is the borrow of the subtract: set when y lies above Y_BASE.
  assign row_full = {1'b0, 8'(Y_BASE)} - {2'b00, y};
  assign row_idx  = row_full[ROW_W-1:0];
  assign pix_ok   = pix_valid && !row_full[8] && (row_full[7:0] < 8'(COL_HEIGHT));
  assign at_x0    = pix_ok && (x == 8'd0);
  assign boundary = at_x0 && (last_x != 8'd0);

  always_comb begin
    state_d    = state_q;
    record     = 1'b0;
    snap_en    = 1'b0;
    clear_live = 1'b0;
    case (state_q)
      IDLE: begin
        if (at_x0) begin
          state_d = ACCUM;
          record  = 1'b1;
        end
      end
      ACCUM: begin
        record = 1'b1;
        if (boundary) begin
          snap_en    = 1'b1;
          clear_live = 1'b1;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        record  = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  // The boundary pixel lands in the freshly cleared maps, so it belongs to the new frame.
  always_comb begin
    rmap_d = clear_live ? '0 : rmap_q;
    pmap_d = clear_live ? '0 : pmap_q;
    if (record && pix_ok && (x == 8'(RUNNER_X)))
      rmap_d[row_idx] = (colour == RUNNER_COLOUR);
    if (record && pix_ok && (x == 8'(PIPE_X)))
      pmap_d[row_idx] = (colour == PIPE_COLOUR);
  end

  always_comb begin
    coll = |(snap_r & snap_p);
`ifdef BOUNDS_CHECK_EN
    // Row 0 is always painted background by the scanner, so row 1 is the floor.
    coll = coll | snap_r[1] | snap_r[COL_HEIGHT-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      state_q    <= IDLE;
      rmap_q     <= '0;
      pmap_q     <= '0;
      snap_r     <= '0;
      snap_p     <= '0;
      last_x     <= 8'd0;
      frame_done <= 1'b0;
      hit        <= 1'b0;
      lose       <= 1'b0;
      frames     <= 16'd0;
    end else begin
      state_q    <= state_d;
      rmap_q     <= rmap_d;
      pmap_q     <= pmap_d;
      if (snap_en) begin
        snap_r <= rmap_q;
        snap_p <= pmap_q;
      end
      if (pix_ok)
        last_x <= x;
      frame_done <= (state_q == EVAL);
      hit        <= (state_q == EVAL) && coll;
      if (state_q == EVAL) begin
        lose   <= lose | coll;
        frames <= frames + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_collision_monitor.sv
// Directed bench for pixel_collision_monitor: frame vectors from a table plus start/reset corner sequences.
module tb_pixel_collision_monitor;

  logic        clk = 1'b0;
  logic        resetn, start, pix_valid;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        frame_done, hit, lose;
  logic [15:0] frames;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int hit_count = 0;

`ifdef BOUNDS_CHECK_EN
  localparam logic BC = 1'b1;
`else
  localparam logic BC = 1'b0;
`endif

  localparam logic [2:0] BG = 3'b011;

  typedef struct {
    logic [79:0] r;
    logic [79:0] p;
    bit          inj;
    logic        exp_hit;
    logic        exp_lose;
  } vec_t;

  vec_t vecs[12];

  pixel_collision_monitor dut (
    .clk(clk), .resetn(resetn), .start(start), .pix_valid(pix_valid),
    .x(x), .y(y), .colour(colour),
    .frame_done(frame_done), .hit(hit), .lose(lose), .frames(frames)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_count <= fd_count + 1;
    if (hit) hit_count <= hit_count + 1;
  end

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [79:0] rng(int lo, int hi);
    logic [79:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic pix(logic v, int xi, int row, logic [2:0] c);
    @(negedge clk);
    pix_valid = v;
    x         = 8'(xi);
    y         = 7'(84 - row);
    colour    = c;
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic send_col(int xi, logic [79:0] m, logic [2:0] on);
    for (int row = 0; row < 80; row++) pix(1'b1, xi, row, m[row] ? on : BG);
  endtask

  task automatic send_frame(logic [79:0] r, logic [79:0] p, bit inj);
    send_col(0, '0, BG);
    send_col(1, r, 3'b100);
    if (inj) begin
      pix(1'b1, 1, 30, 3'b100);   // overwritten by the next pixel
      pix(1'b1, 1, 30, BG);
      pix(1'b0, 1, 30, 3'b100);   // not valid
      pix(1'b1, 1, -43, 3'b100);  // y = 127, negative row
      pix(1'b1, 1, 80, 3'b100);   // y = 4, row past the column
      pix(1'b1, 0, -16, BG);      // x = 0 but out of range: not a boundary
      pix(1'b1, 0, 80, BG);
    end
    send_col(2, p, 3'b110);
    send_col(3, '0, BG);
  endtask

  initial begin
    int fd0, hc0;

    vecs[0]  = '{rng(40,43), rng(0,39) | rng(53,79), 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{rng(40,43), rng(42,79),             1'b0, 1'b1, 1'b1};
    for (int i = 2; i <= 6; i++)
      vecs[i] = '{rng(40,43), rng(0,39), 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{rng(1,4),   '0,        1'b0, BC,   1'b1};
    vecs[8]  = '{rng(79,79), '0,        1'b0, BC,   1'b1};
    vecs[9]  = '{rng(0,0),   rng(0,0),  1'b0, 1'b1, 1'b1};
    vecs[10] = '{rng(0,0),   '0,        1'b0, 1'b0, 1'b1};
    vecs[11] = '{'0,         '1,        1'b1, 1'b0, 1'b1};

    resetn = 1'b0; start = 1'b0; pix_valid = 1'b0; x = '0; y = '0; colour = '0;
    repeat (3) @(negedge clk);
    chk1("rst frame_done", frame_done, 1'b0);
    chk1("rst hit", hit, 1'b0);
    chk1("rst lose", lose, 1'b0);
    chk16("rst frames", frames, 16'd0);
    resetn = 1'b1;

    // Three background frames: only the second and third boundaries evaluate.
    fd0 = fd_count; hc0 = hit_count;
    repeat (3) send_frame('0, '0, 1'b0);
    idle();
    chk16("idle pulses", 16'(fd_count - fd0), 16'd2);
    chk16("idle frames", frames, 16'd2);
    chk16("idle hits", 16'(hit_count - hc0), 16'd0);
    chk1("idle lose", lose, 1'b0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk16("start frames", frames, 16'd0);

    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].r, vecs[i].p, vecs[i].inj);
      pix(1'b1, 0, 0, BG);
      idle();
      chk1($sformatf("v%0d fd_early", i), frame_done, 1'b0);
      @(negedge clk);
      chk1($sformatf("v%0d frame_done", i), frame_done, 1'b1);
      chk1($sformatf("v%0d hit", i), hit, vecs[i].exp_hit);
      chk1($sformatf("v%0d lose", i), lose, vecs[i].exp_lose);
      chk16($sformatf("v%0d frames", i), frames, 16'(i + 1));
      @(negedge clk);
      chk1($sformatf("v%0d fd_late", i), frame_done, 1'b0);
      chk1($sformatf("v%0d hit_late", i), hit, 1'b0);
    end

    // start mid-frame while lose is set
    send_col(0, '0, BG);
    send_col(1, rng(40,43), 3'b100);
    @(negedge clk);
    pix_valid = 1'b1; x = 8'd2; y = 7'd24; colour = 3'b110; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0;
    chk1("mid start lose", lose, 1'b0);
    chk16("mid start frames", frames, 16'd0);
    chk1("mid start fd", frame_done, 1'b0);
    fd0 = fd_count;
    send_col(2, '1, 3'b110);
    send_col(3, '0, BG);
    pix(1'b1, 0, 0, BG);
    repeat (3) idle();
    chk16("no pulse after start", 16'(fd_count - fd0), 16'd0);

    // start coincident with a boundary pixel: start wins, live maps cleared
    send_col(1, rng(40,43), 3'b100);
    @(negedge clk);
    pix_valid = 1'b1; x = 8'd0; y = 7'd74; colour = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0;
    repeat (3) idle();
    chk16("coincident no pulse", 16'(fd_count - fd0), 16'd0);
    chk16("coincident frames", frames, 16'd0);
    send_col(0, '0, BG);
    send_col(2, '1, 3'b110);
    pix(1'b1, 0, 0, BG);
    idle();
    @(negedge clk);
    chk1("after clear fd", frame_done, 1'b1);
    chk1("after clear hit", hit, 1'b0);
    chk16("after clear frames", frames, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_collision_monitor.md
# pixel_collision_monitor

- Snoops the `(x, y, colour)` plot stream that the display scanner drives into `vga_adapter`.
- Reconstructs two 80-row bitmaps per frame: the runner's column and the nearest pipe column.
- Flags a collision at each frame boundary and feeds `lose` back to the game datapath, replacing the height-only ground/ceiling loss check.
- Sits between the display scanner output and the control/datapath `lose` input.

## Interface

Parameters:
- `Y_BASE`, 84: screen y of row 0; row index = `Y_BASE - y`.
- `COL_HEIGHT`, 80: rows per column; valid row indices are 0..`COL_HEIGHT-1`.
- `RUNNER_X`, 1: x of the runner column sampled into the runner map.
- `PIPE_X`, 2: x of the first pipe column sampled into the pipe map.
- `RUNNER_COLOUR`, 3'b100: colour marking a runner pixel.
- `PIPE_COLOUR`, 3'b110: colour marking a pipe pixel.

Ports:
- `clk`, in, 1: system clock (CLOCK_50).
- `resetn`, in, 1: synchronous, active-low reset.
- `start`, in, 1: synchronous clear, the game-ready strobe from control.
- `pix_valid`, in, 1: a plot write is present this cycle.
- `x`, in, 8: plot x.
- `y`, in, 7: plot y.
- `colour`, in, 3: plot colour.
- `frame_done`, out, 1: one-cycle pulse per evaluated frame.
- `hit`, out, 1: one-cycle pulse, coincident with `frame_done`, when the frame collided.
- `lose`, out, 1: sticky collision flag.
- `frames`, out, 16: count of evaluated frames since the last clear; wraps at 0xFFFF to 0.

## Operation

- The row is computed as `Y_BASE - y` with an 8-bit subtract. A pixel is ignored if the row is negative, the row is ≥ `COL_HEIGHT`, or `pix_valid` = 0.
- Live maps `rmap[COL_HEIGHT-1:0]` and `pmap[COL_HEIGHT-1:0]`:
  - On a valid pixel with x = `RUNNER_X`, `rmap[row]` is set to (colour == `RUNNER_COLOUR`).
  - On a valid pixel with x = `PIPE_X`, `pmap[row]` is set to (colour == `PIPE_COLOUR`).
  - Each bit is written, not OR-ed, so rewrites overwrite.
- `last_x` holds the x of the most recent valid pixel.
- Boundary: a valid pixel with x = 0 while `last_x` ≠ 0.
- State machine:
  - IDLE: no evaluation. Moves to ACCUM on the first valid pixel with x = 0; that pixel is recorded.
  - ACCUM: records pixels. On a boundary pixel it does all of the following in one cycle, then moves to EVAL:
    - copies `rmap`/`pmap` into snapshot registers;
    - clears the live maps;
    - records the boundary pixel into the cleared maps.
  - EVAL: computes `coll = |(snap_r & snap_p)` and registers `frame_done` = 1, `hit` = `coll`, `lose` ← `lose | coll`, `frames` + 1. Records any pixel arriving this cycle. Returns to ACCUM unconditionally.
- A boundary cannot occur in EVAL: the boundary pixel set `last_x` = 0.
- The first partial frame after IDLE is discarded; it has no snapshot.
- `start` = 1 (and reset) clears:
  - the maps, the snapshots, and `last_x` (to 0);
  - `lose`, `frames`, `hit`, `frame_done`;
  - the state, to IDLE.
- `start` has priority over any pixel or boundary in the same cycle.

## Timing

- Reset values: `frame_done` = 0, `hit` = 0, `lose` = 0, `frames` = 0, state IDLE, all maps zero.
- Latency, with the boundary pixel sampled at edge N:
  - snapshot captured at edge N;
  - outputs registered at edge N+1;
  - `frame_done` and `hit` visible for exactly the one cycle between edges N+1 and N+2;
  - `lose` rises in that same cycle and holds until `start` or reset.
- Sustains one pixel per cycle. No back-pressure and no pixel is dropped, including during EVAL.
- Reset or `start` mid-frame discards the partial frame. No pulse follows.
- `frames` increments once per EVAL.

## Configuration

- `BOUNDS_CHECK_EN` defined:
  - EVAL also sets `coll` if `snap_r[1]` or `snap_r[COL_HEIGHT-1]` is set, i.e. the runner touches the floor or ceiling row.
  - Row 0 is excluded because the scanner always paints it background.
- Not defined: collision is runner/pipe overlap only, and the runner touching a bound never asserts `hit`.

## Test plan

- Reset, then idle stream of x = 0..3 rows with colour 3'b011 for 3 frames -> `frame_done` pulses at frames 2 and 3; `frames` = 2; `hit` = 0; `lose` = 0.
- Runner rows 40..43 at x = 1, pipe rows 0..39 and 53..79 at x = 2, then boundary -> `hit` = 0.
- Shift the pipe so rows 42..79 are pipe, then boundary -> `hit` = 1 and `frame_done` = 1 two edges after the boundary pixel; `lose` = 1 and stays 1 across 5 further clean frames.
- `start` pulsed while `lose` = 1 and mid-frame -> next cycle `lose` = 0, `frames` = 0, state IDLE; the next boundary produces no pulse.
- Boundary pixel with x = 0, row 10, runner colour coincident with `start` = 1 -> `start` wins: maps are zero and no evaluation occurs.
- With `BOUNDS_CHECK_EN`, runner at rows 1..4 and no pipe -> `hit` = 1. Without the macro, the same stimulus -> `hit` = 0.
